// File: rtl/pipe_gen_if.sv
// pipe_gen_if
// Groups the per-pixel counts, frame/game status and the obstacle generator
// outputs into one bundle.
//   i_H_count / i_V_count : current column / row from frame_counter (10 b)
//   i_Frame_end           : one-cycle pulse per frame
//   i_Run / i_Dead        : game-running level, bird-dead level
//   o_Draw_Pipe           : registered per-pixel pipe flag
//   o_Score / o_Score_Pulse : pipes passed (saturating) and its increment pulse
// master drives the counts/status (frame logic or bench), slave is pipe_gen.
interface pipe_gen_if;
    logic [9:0] i_H_count;
    logic [9:0] i_V_count;
    logic       i_Frame_end;
    logic       i_Run;
    logic       i_Dead;
    logic       o_Draw_Pipe;
    logic [7:0] o_Score;
    logic       o_Score_Pulse;

    modport master (
        output i_H_count, i_V_count, i_Frame_end, i_Run, i_Dead,
        input  o_Draw_Pipe, o_Score, o_Score_Pulse
    );

    modport slave (
        input  i_H_count, i_V_count, i_Frame_end, i_Run, i_Dead,
        output o_Draw_Pipe, o_Score, o_Score_Pulse
    );
endinterface

// File: rtl/pipe_gen.sv
// pipe_gen
// Obstacle generator for the Flappy Bird datapath. Keeps NUM_PIPES scrolling
// pipe columns, moves them SPEED pixels per frame while running, respawns a
// column at the right edge once it has scrolled off the left, raises a
// registered per-pixel draw flag and counts the pipes the bird has passed.
// Ports:
//   i_Clk      : system clock (same as frame_counter)
//   i_Reset_n  : asynchronous active-low reset
//   bus        : pipe_gen_if.slave (H/V counts, frame pulse, run/dead status,
//                draw flag, score, score pulse)
// Build option: define PIPE_RANDOM_GAP_EN to add an 8-bit LFSR that
// randomises the gap top of each respawned pipe (GAP_MIN + lfsr). Without it
// every gap top is fixed at (V_ACTIVE-GAP_H)/2.
module pipe_gen #(
    parameter int          H_ACTIVE  = 640,
    parameter int          V_ACTIVE  = 480,
    parameter int          PIPE_W    = 32,
    parameter int          GAP_H     = 120,
    parameter int          GAP_MIN   = 40,
    parameter int          NUM_PIPES = 3,
    parameter int          SPACING   = 224,
    parameter int          SPEED     = 2,
    parameter int          BIRD_X    = 160,
    parameter logic [7:0]  LFSR_SEED = 8'hA5
) (
    input  logic      i_Clk,
    input  logic      i_Reset_n,
    pipe_gen_if.slave bus
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_FROZEN = 2'd2
    } state_t;

    localparam logic [10:0] WRAP_W    = 11'(NUM_PIPES * SPACING);
    localparam logic [10:0] R_BASE    = 11'(H_ACTIVE + PIPE_W);
    localparam logic [10:0] SPEED_W   = 11'(SPEED);
    localparam logic [10:0] BIRD_X_W  = 11'(BIRD_X);
    localparam logic [10:0] PIPE_W_W  = 11'(PIPE_W);
    localparam logic [10:0] GAP_H_W   = 11'(GAP_H);
    localparam logic [10:0] H_ACT_W   = 11'(H_ACTIVE);
    localparam logic [10:0] V_ACT_W   = 11'(V_ACTIVE);
`ifdef PIPE_RANDOM_GAP_EN
    localparam logic [8:0]  G_INIT    = 9'(GAP_MIN + 100);
    localparam logic [7:0]  SEED_EFF  = (LFSR_SEED == 8'h00) ? 8'h01 : LFSR_SEED;

    // x^8+x^6+x^5+x^4+1 Fibonacci step, shifting left.
    function automatic logic [7:0] lfsr_step(input logic [7:0] cur);
        return {cur[6:0], cur[7] ^ cur[5] ^ cur[4] ^ cur[3]};
    endfunction
`else
    localparam logic [8:0]  G_INIT    = 9'((V_ACTIVE - GAP_H) / 2);
`endif

    state_t      state_r;
    logic [10:0] r_r [NUM_PIPES];
    logic [8:0]  g_r [NUM_PIPES];
    logic [7:0]  score_r;
    logic        score_pulse_r;
    logic        draw_r;
`ifdef PIPE_RANDOM_GAP_EN
    logic [7:0]  lfsr_r;
`endif

    logic [10:0] r_next_s [NUM_PIPES];
    logic [8:0]  g_next_s [NUM_PIPES];
    logic [8:0]  gap_respawn_s;
    logic        pass_s;
    logic        draw_s;
    logic [10:0] h_s;
    logic [10:0] v_s;

    // Next slot positions for a frame step, and whether a slot crosses the bird.
    always_comb begin
        pass_s = 1'b0;
`ifdef PIPE_RANDOM_GAP_EN
        gap_respawn_s = 9'(GAP_MIN) + {1'b0, lfsr_r};
`else
        gap_respawn_s = G_INIT;
`endif
        for (int k = 0; k < NUM_PIPES; k++) begin
            if (r_r[k] <= SPEED_W) begin
                // Off the left edge: jump back one full ring of slots.
                r_next_s[k] = r_r[k] - SPEED_W + WRAP_W;
                g_next_s[k] = gap_respawn_s;
            end else begin
                r_next_s[k] = r_r[k] - SPEED_W;
                g_next_s[k] = g_r[k];
            end
            pass_s = pass_s | ((r_r[k] > BIRD_X_W) && (r_next_s[k] <= BIRD_X_W));
        end
    end

    // Pixel hit test against every slot; r-PIPE_W wraps in 11 bits by design.
    always_comb begin
        draw_s = 1'b0;
        h_s    = {1'b0, bus.i_H_count};
        v_s    = {1'b0, bus.i_V_count};
        for (int k = 0; k < NUM_PIPES; k++) begin
            draw_s = draw_s |
                     ((h_s >= (r_r[k] - PIPE_W_W)) && (h_s < r_r[k]) &&
                      ((v_s < {2'b00, g_r[k]}) ||
                       (v_s >= ({2'b00, g_r[k]} + GAP_H_W))));
        end
        draw_s = draw_s & (h_s < H_ACT_W) & (v_s < V_ACT_W);
    end

    // Game state machine, slot motion, LFSR and score.
    always_ff @(posedge i_Clk or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            state_r       <= ST_IDLE;
            score_r       <= 8'd0;
            score_pulse_r <= 1'b0;
            for (int k = 0; k < NUM_PIPES; k++) begin
                r_r[k] <= R_BASE + 11'(k * SPACING);
                g_r[k] <= G_INIT;
            end
`ifdef PIPE_RANDOM_GAP_EN
            lfsr_r <= SEED_EFF;
`endif
        end else begin
            score_pulse_r <= 1'b0;
            if (!bus.i_Run) begin
                // Dropping run wins over everything and parks the pipes.
                state_r <= ST_IDLE;
                score_r <= 8'd0;
                for (int k = 0; k < NUM_PIPES; k++) begin
                    r_r[k] <= R_BASE + 11'(k * SPACING);
                    g_r[k] <= G_INIT;
                end
            end else begin
                case (state_r)
                    ST_IDLE: begin
                        state_r <= ST_RUN;
                    end
                    ST_RUN: begin
                        if (bus.i_Dead) begin
                            state_r <= ST_FROZEN;
                        end else if (bus.i_Frame_end) begin
                            for (int k = 0; k < NUM_PIPES; k++) begin
                                r_r[k] <= r_next_s[k];
                                g_r[k] <= g_next_s[k];
                            end
`ifdef PIPE_RANDOM_GAP_EN
                            lfsr_r <= lfsr_step(lfsr_r);
`endif
                            if (pass_s) begin
                                score_pulse_r <= 1'b1;
                                score_r <= (score_r == 8'hFF) ? 8'hFF : score_r + 8'd1;
                            end else begin
                                score_r <= score_r;
                            end
                        end else begin
                            state_r <= ST_RUN;
                        end
                    end
                    ST_FROZEN: begin
                        state_r <= ST_FROZEN;
                    end
                    default: begin
                        state_r <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    // One-cycle registered draw flag for the colour mux.
    always_ff @(posedge i_Clk or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            draw_r <= 1'b0;
        end else begin
            draw_r <= draw_s;
        end
    end

    assign bus.o_Draw_Pipe   = draw_r;
    assign bus.o_Score       = score_r;
    assign bus.o_Score_Pulse = score_pulse_r;

endmodule

// File: tb/tb_pipe_gen.sv
// tb_pipe_gen
// Scoreboarded bench for pipe_gen: a behavioural model of the slots, LFSR,
// game state and score produces the expected draw flag and score pulse for
// every clock; observed outputs are queued alongside and compared per test.
module tb_pipe_gen;
    logic clk;
    logic rst_n;
    int   total = 0;
    int   bad   = 0;

    pipe_gen_if bus();

    pipe_gen dut (
        .i_Clk     (clk),
        .i_Reset_n (rst_n),
        .bus       (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model state
    int          st_m;
    logic [10:0] r_m [3];
    logic [8:0]  g_m [3];
    logic [7:0]  lfsr_m;
    logic [7:0]  score_m;

    // Scoreboard queues
    logic exp_draw_q[$];
    logic obs_draw_q[$];
    logic exp_pulse_q[$];
    logic obs_pulse_q[$];

    function automatic logic [8:0] init_gap();
`ifdef PIPE_RANDOM_GAP_EN
        return 9'd140;
`else
        return 9'd180;
`endif
    endfunction

    task automatic model_slots_init();
        for (int k = 0; k < 3; k++) begin
            r_m[k] = 11'd672 + 11'(k * 224);
            g_m[k] = init_gap();
        end
    endtask

    function automatic logic model_draw(input logic [9:0] hc, input logic [9:0] vc);
        logic        d;
        logic [10:0] c;
        logic [10:0] v;
        logic [10:0] lo;
        d = 1'b0;
        c = {1'b0, hc};
        v = {1'b0, vc};
        if (c < 11'd640 && v < 11'd480) begin
            for (int k = 0; k < 3; k++) begin
                lo = r_m[k] - 11'd32;
                if (c >= lo && c < r_m[k] &&
                    (v < {2'b00, g_m[k]} || v >= {2'b00, g_m[k]} + 11'd120))
                    d = 1'b1;
            end
        end
        return d;
    endfunction

    task automatic model_step();
        logic        hit;
        logic [10:0] nr;
        hit = 1'b0;
        if (!bus.i_Run) begin
            st_m = 0;
            model_slots_init();
            score_m = 8'd0;
        end else if (st_m == 0) begin
            st_m = 1;
        end else if (st_m == 1) begin
            if (bus.i_Dead) begin
                st_m = 2;
            end else if (bus.i_Frame_end) begin
                for (int k = 0; k < 3; k++) begin
                    if (r_m[k] <= 11'd2) begin
                        nr = r_m[k] + 11'd670;
`ifdef PIPE_RANDOM_GAP_EN
                        g_m[k] = 9'd40 + {1'b0, lfsr_m};
`else
                        g_m[k] = 9'd180;
`endif
                    end else begin
                        nr = r_m[k] - 11'd2;
                    end
                    if (r_m[k] > 11'd160 && nr <= 11'd160) hit = 1'b1;
                    r_m[k] = nr;
                end
`ifdef PIPE_RANDOM_GAP_EN
                lfsr_m = {lfsr_m[6:0], lfsr_m[7] ^ lfsr_m[5] ^ lfsr_m[4] ^ lfsr_m[3]};
`endif
                if (hit && score_m != 8'd255) score_m = score_m + 8'd1;
            end
        end
        exp_pulse_q.push_back(hit);
    endtask

    // One clock: record expectations for the coming edge, then sample outputs.
    task automatic cycle();
        exp_draw_q.push_back(model_draw(bus.i_H_count, bus.i_V_count));
        model_step();
        @(negedge clk);
        obs_draw_q.push_back(bus.o_Draw_Pipe);
        obs_pulse_q.push_back(bus.o_Score_Pulse);
    endtask

    task automatic flush();
        exp_draw_q.delete();
        obs_draw_q.delete();
        exp_pulse_q.delete();
        obs_pulse_q.delete();
    endtask

    task automatic frame();
        bus.i_Frame_end = 1'b1;
        cycle();
        bus.i_Frame_end = 1'b0;
        cycle();
    endtask

    task automatic test_reset();
        logic e;
        logic o;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        total++; if (bus.o_Draw_Pipe !== 1'b0) begin bad++; $display("FAIL reset_draw got=%0b want=0", bus.o_Draw_Pipe); end
        total++; if (bus.o_Score !== 8'd0) begin bad++; $display("FAIL reset_score got=%0d want=0", bus.o_Score); end
        total++; if (bus.o_Score_Pulse !== 1'b0) begin bad++; $display("FAIL reset_pulse got=%0b want=0", bus.o_Score_Pulse); end
        rst_n = 1'b1;
        st_m = 0;
        model_slots_init();
        lfsr_m  = 8'hA5;
        score_m = 8'd0;
        flush();
        for (int v = 0; v < 525; v += 16) begin
            for (int h = 0; h < 800; h += 8) begin
                bus.i_H_count = 10'(h);
                bus.i_V_count = 10'(v);
                cycle();
                e = exp_draw_q.pop_front();
                o = obs_draw_q.pop_front();
                total++; if (o !== e || o !== 1'b0) begin bad++; $display("FAIL idle_sweep h=%0d v=%0d got=%0b want=%0b", h, v, o, e); end
            end
        end
        total++; if (bus.o_Score !== 8'd0) begin bad++; $display("FAIL idle_score got=%0d want=0", bus.o_Score); end
        flush();
    endtask

    task automatic test_motion();
        int   px_h [8] = '{620, 620, 620, 600, 608, 607, 639, 640};
        int   px_v [8] = '{100, 200, 300, 100, 100, 100, 479, 100};
        logic px_e [8] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        logic o;
        logic e;
        bus.i_Run = 1'b1;
        cycle();
        repeat (16) frame();
        flush();
        for (int i = 0; i < 8; i++) begin
            bus.i_H_count = 10'(px_h[i]);
            bus.i_V_count = 10'(px_v[i]);
            cycle();
            e = exp_draw_q.pop_front();
            o = obs_draw_q.pop_front();
            total++; if (o !== px_e[i] || e !== px_e[i]) begin bad++; $display("FAIL motion_px (%0d,%0d) got=%0b want=%0b", px_h[i], px_v[i], o, px_e[i]); end
        end
        flush();
    endtask

    task automatic test_score_respawn();
        int   pulses;
        logic o;
        logic e;
        pulses = 0;
        bus.i_H_count = 10'd700;
        bus.i_V_count = 10'd100;
        for (int f = 17; f <= 336; f++) begin
            frame();
            for (int j = 0; j < 2; j++) begin
                e = exp_pulse_q.pop_front();
                o = obs_pulse_q.pop_front();
                if (o === 1'b1) pulses++;
                if (f == 256 && j == 0) begin
                    total++; if (o !== 1'b1) begin bad++; $display("FAIL score_pulse_256 got=%0b want=1", o); end
                end else begin
                    total++; if (o !== e) begin bad++; $display("FAIL score_pulse f=%0d got=%0b want=%0b", f, o, e); end
                end
            end
            if (f == 256) begin
                total++; if (bus.o_Score !== 8'd1) begin bad++; $display("FAIL score_256 got=%0d want=1", bus.o_Score); end
            end
        end
        total++; if (pulses != 1) begin bad++; $display("FAIL score_pulse_count got=%0d want=1", pulses); end
        total++; if (bus.o_Score !== 8'd1) begin bad++; $display("FAIL score_336 got=%0d want=1", bus.o_Score); end
        flush();
        // Slot 0 respawned to 672 (off-screen); slots 1/2 at 224 and 448.
        begin
            int   rh [4] = '{639, 200, 430, 450};
            logic re [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
            for (int i = 0; i < 4; i++) begin
                bus.i_H_count = 10'(rh[i]);
                bus.i_V_count = 10'd100;
                cycle();
                e = exp_draw_q.pop_front();
                o = obs_draw_q.pop_front();
                total++; if (o !== re[i] || e !== re[i]) begin bad++; $display("FAIL respawn_px h=%0d got=%0b want=%0b", rh[i], o, re[i]); end
            end
        end
        // Scroll the respawned pipe into view and scan its column for the new gap.
        repeat (20) frame();
        flush();
        for (int v = 0; v < 480; v += 4) begin
            bus.i_H_count = 10'd615;
            bus.i_V_count = 10'(v);
            cycle();
            e = exp_draw_q.pop_front();
            o = obs_draw_q.pop_front();
            total++; if (o !== e) begin bad++; $display("FAIL respawn_gap v=%0d got=%0b want=%0b", v, o, e); end
        end
        flush();
    endtask

    task automatic test_freeze();
        int   fh [5] = '{471, 472, 440, 439, 455};
        int   fv [5] = '{100, 100, 100, 100, 200};
        logic fe [5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        logic o;
        logic e;
        bus.i_Run = 1'b0;
        cycle();
        total++; if (bus.o_Score !== 8'd0) begin bad++; $display("FAIL freeze_clear_score got=%0d want=0", bus.o_Score); end
        bus.i_Run = 1'b1;
        cycle();
        repeat (100) frame();
        bus.i_Dead = 1'b1;
        repeat (6) frame();
        flush();
        for (int i = 0; i < 5; i++) begin
            bus.i_H_count = 10'(fh[i]);
            bus.i_V_count = 10'(fv[i]);
            cycle();
            e = exp_draw_q.pop_front();
            o = obs_draw_q.pop_front();
            total++; if (o !== fe[i] || e !== fe[i]) begin bad++; $display("FAIL frozen_px (%0d,%0d) got=%0b want=%0b", fh[i], fv[i], o, fe[i]); end
        end
        flush();
    endtask

    task automatic test_idle_restore();
        logic o;
        bus.i_Run  = 1'b0;
        bus.i_Dead = 1'b0;
        cycle();
        total++; if (bus.o_Score !== 8'd0) begin bad++; $display("FAIL idle_score got=%0d want=0", bus.o_Score); end
        repeat (3) frame();
        flush();
        for (int h = 0; h < 640; h += 4) begin
            bus.i_H_count = 10'(h);
            bus.i_V_count = 10'd100;
            cycle();
            void'(exp_draw_q.pop_front());
            o = obs_draw_q.pop_front();
            total++; if (o !== 1'b0) begin bad++; $display("FAIL idle_row h=%0d got=%0b want=0", h, o); end
        end
        flush();
    endtask

    task automatic test_back_to_back();
        logic o;
        logic e;
        bus.i_Run = 1'b1;
        cycle();
        repeat (255) frame();
        flush();
        // Slot 0 sits at 162: a move would score, but run drops on the same edge.
        bus.i_Run       = 1'b0;
        bus.i_Frame_end = 1'b1;
        cycle();
        bus.i_Frame_end = 1'b0;
        e = exp_pulse_q.pop_front();
        o = obs_pulse_q.pop_front();
        total++; if (o !== 1'b0 || e !== 1'b0) begin bad++; $display("FAIL runfall_pulse got=%0b want=0", o); end
        total++; if (bus.o_Score !== 8'd0) begin bad++; $display("FAIL runfall_score got=%0d want=0", bus.o_Score); end
        flush();
    endtask

    task automatic test_saturate();
        int   pulses;
        logic o;
        logic e;
        pulses = 0;
        bus.i_Run = 1'b1;
        cycle();
        flush();
        for (int f = 1; f <= 28816; f++) begin
            frame();
            for (int j = 0; j < 2; j++) begin
                e = exp_pulse_q.pop_front();
                o = obs_pulse_q.pop_front();
                if (o === 1'b1) pulses++;
                total++; if (o !== e) begin bad++; $display("FAIL sat_pulse f=%0d got=%0b want=%0b", f, o, e); end
                if (f == 28816 && j == 0) begin
                    total++; if (o !== 1'b1) begin bad++; $display("FAIL sat_last_pulse got=%0b want=1", o); end
                end
            end
            exp_draw_q.delete();
            obs_draw_q.delete();
            if (f == 28704) begin
                total++; if (bus.o_Score !== 8'd255) begin bad++; $display("FAIL sat_reach got=%0d want=255", bus.o_Score); end
            end
        end
        total++; if (bus.o_Score !== 8'd255) begin bad++; $display("FAIL sat_hold got=%0d want=255", bus.o_Score); end
        total++; if (pulses != 256) begin bad++; $display("FAIL sat_pulse_count got=%0d want=256", pulses); end
        flush();
    endtask

    initial begin
        rst_n           = 1'b0;
        bus.i_H_count   = 10'd0;
        bus.i_V_count   = 10'd0;
        bus.i_Frame_end = 1'b0;
        bus.i_Run       = 1'b0;
        bus.i_Dead      = 1'b0;
        test_reset();
        test_motion();
        test_score_respawn();
        test_freeze();
        test_idle_restore();
        test_back_to_back();
        test_saturate();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/pipe_gen.md
# pipe_gen

Obstacle generator for the Flappy Bird datapath. It holds a set of scrolling pipe columns, advances them once per video frame, and respawns each pipe at the right edge with a new gap height. It raises a registered per-pixel draw flag from the frame counter's H/V counts and keeps the score. It sits beside `bird_ctrl_fsm`: it consumes the same `frame_counter` H/V counts plus the start/dead status, and its outputs feed the VGA colour mux, collision logic and the 7-segment score display.

## Interface
- `H_ACTIVE`, 640: visible columns.
- `V_ACTIVE`, 480: visible rows.
- `PIPE_W`, 32: pipe width in pixels.
- `GAP_H`, 120: vertical gap height in pixels.
- `GAP_MIN`, 40: smallest gap-top row.
- `NUM_PIPES`, 3: number of pipe slots.
- `SPACING`, 224: horizontal distance between slots. `NUM_PIPES*SPACING` must equal `H_ACTIVE+PIPE_W`.
- `SPEED`, 2: pixels moved per frame. Must be even and must divide `SPACING`.
- `BIRD_X`, 160: bird's left column, used for scoring.
- `LFSR_SEED`, 8'hA5: LFSR reset value. A seed of 0 is forced to 8'h01.
- Clock and reset: one clock; reset is asynchronous and active-low.
- `i_Clk`  in  1  system clock, the same clock as `frame_counter`.
- `i_Reset_n`  in  1  asynchronous, active-low reset.
- `i_H_count`  in  10  current column from `frame_counter`.
- `i_V_count`  in  10  current row from `frame_counter`.
- `i_Frame_end`  in  1  single-cycle pulse, once per frame.
- `i_Run`  in  1  game-running level (start toggle).
- `i_Dead`  in  1  bird-dead level from `bird_ctrl_fsm`.
- `o_Draw_Pipe`  out  1  current pixel belongs to a pipe (registered).
- `o_Score`  out  8  pipes passed, binary, saturates at 255.
- `o_Score_Pulse`  out  1  single-cycle pulse on each score increment.

## Operation
- Per slot k, state is:
  - `r[k]`, 11-bit right edge (exclusive).
  - `g[k]`, 9-bit gap top.
- Initial/IDLE values:
  - `r[k] = H_ACTIVE+PIPE_W + k*SPACING`, i.e. 672, 896, 1120.
  - `g[k] = GAP_MIN+100` = 140.
- State machine:
  - IDLE → RUN when `i_Run`=1.
  - RUN → FROZEN when `i_Dead`=1.
  - RUN → IDLE when `i_Run`=0.
  - FROZEN → IDLE when `i_Run`=0.
  - `i_Run`=0 takes priority over `i_Dead`.
  - Entering IDLE restores the initial slot values and clears `o_Score`. The LFSR is not reset.
- Motion, in RUN on each `i_Frame_end`:
  - If `r[k] <= SPEED`: `r[k] <= r[k]-SPEED+NUM_PIPES*SPACING` and `g[k] <= GAP_MIN + lfsr`.
  - Otherwise: `r[k] <= r[k]-SPEED`.
  - All slots update in the same cycle.
- LFSR: 8-bit Fibonacci, taps x^8+x^6+x^5+x^4+1, shifted left. It steps on every `i_Frame_end` in RUN. All slots respawning in the same frame take the same value.
- Draw condition for a pixel (c = `i_H_count`, v = `i_V_count`): c < H_ACTIVE, v < V_ACTIVE, and for some k:
  - `r[k]-PIPE_W <= c < r[k]`, and
  - `v < g[k]` or `v >= g[k]+GAP_H`.
- Comparisons are 11-bit unsigned; `i_H_count` is zero-extended.
- Drawing is active in every state. In IDLE nothing is visible, because all pipes are off-screen.
- Score: when a slot steps from `r > BIRD_X` to `r <= BIRD_X`, `o_Score` increments (saturating) and `o_Score_Pulse` fires.
- An `i_Frame_end` while in FROZEN or IDLE is ignored.

## Timing
- Reset values:
  - `o_Draw_Pipe`=0, `o_Score`=0, `o_Score_Pulse`=0.
  - State IDLE, slots at their initial values, LFSR = seed.
- `o_Draw_Pipe` reflects the H/V counts from the previous cycle (1-cycle latency). The downstream colour mux delays syncs to match.
- Slot update, LFSR step, score update and `o_Score_Pulse` all take effect on the clock edge that samples `i_Frame_end`=1. The pulse lasts exactly one cycle.
- Simultaneous events on one edge:
  - `i_Dead` rising with `i_Frame_end` in RUN: enter FROZEN, no move.
  - `i_Run` falling with `i_Frame_end`: enter IDLE, no move, no score.
- Reset asserted mid-frame forces all reset values immediately. Deassertion is synchronised by the integrator.

## Configuration
- `PIPE_RANDOM_GAP_EN` defined: LFSR instantiated; respawn gap = `GAP_MIN + lfsr`, range 40..295.
- Not defined: LFSR removed; every gap top is fixed at `(V_ACTIVE-GAP_H)/2` = 180, including the initial values.

## Test plan
- Reset, hold `i_Run`=0, sweep one full frame → `o_Draw_Pipe` never 1; `o_Score`=0.
- Macro off, `i_Run`=1, 16 `i_Frame_end` pulses → `r[0]`=640. Pixel (620,100) → 1, (620,200) → 0, (620,300) → 1, (600,100) → 0, each seen one cycle after the count.
- `i_Run`=1, 256 frames → `o_Score`=1 with exactly one `o_Score_Pulse` on the 256th frame. At 336 frames, `r[0]`=672 (respawn). Macro on: `g[0]` = 40 + LFSR value at that step.
- At frame 100, `i_Dead`=1 coincident with `i_Frame_end` → `r[0]` stays 472 for later frames; pipe pixels are still drawn.
- From FROZEN, drop `i_Run` → IDLE; `r[k]` back to 672/896/1120; `o_Score`=0.
- Preload `o_Score`=255 via long run (or force), then trigger a pass → `o_Score` stays 255; `o_Score_Pulse` still fires.
